fft_bitrev_reader: RTL and testbench

- Read-side engine for the FFT dual-port RAM. On a start command it walks all 2^ADDR_BIT_WIDTH locations, in natural or bit-reversed order.
- It drives the RAM read address and captures the RAM read data, which the RAM updates on the falling clock edge.
- It streams the samples out over a valid/ready interface through a 2-entry output buffer, so downstream backpressure never loses a sample.
- It sits between the FFT working RAM and the output/unload stage.

---
 rtl/fft_bitrev_reader.sv | 161 ++++++++++++++++
 tb/tb_fft_bitrev_reader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reader.sv
// fft_bitrev_reader: read-side engine for the FFT working RAM.
// Walks all 2^ADDR_BIT_WIDTH addresses in natural or bit-reversed order.
// Captures the RAM word one cycle after each address is issued.
// Streams the words out through a 2-entry valid/ready buffer.
// An issue is allowed only while buffer occupancy plus the outstanding read
// leaves room, so backpressure never drops a sample.
module fft_bitrev_reader #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int ADDR_BIT_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      bitrev_en,
  output logic [ADDR_BIT_WIDTH-1:0] read_addr,
  input  logic [DATA_BIT_WIDTH-1:0] ram_data,
  output logic [DATA_BIT_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_BIT_WIDTH-1:0] IDX_ONE  = ADDR_BIT_WIDTH'(1);
  localparam logic [ADDR_BIT_WIDTH-1:0] IDX_LAST = '1;

  // Mirror the address bits: bit i moves to bit ADDR_BIT_WIDTH-1-i.
  function automatic logic [ADDR_BIT_WIDTH-1:0] bit_reverse(
    input logic [ADDR_BIT_WIDTH-1:0] v
  );
    logic [ADDR_BIT_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < ADDR_BIT_WIDTH; i++) begin
      r[i] = v[ADDR_BIT_WIDTH-1-i];
    end
    return r;
  endfunction

  // Control state
  logic [1:0]                r_state;
  logic [ADDR_BIT_WIDTH-1:0] r_idx;
  logic                      r_bitrev;
  logic [ADDR_BIT_WIDTH-1:0] r_read_addr;
  logic                      r_inflight;
  logic                      r_inflight_last;

  // Output buffer: two entries, head at r_rd_ptr
  logic [DATA_BIT_WIDTH-1:0] r_buf_data [2];
  logic [1:0]                r_buf_last;
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;

  logic                      w_valid;
  logic                      w_pop;
  logic                      w_head_last;
  logic [2:0]                w_occ_after;
  logic                      w_issue;
  logic                      w_issue_last;
  logic [ADDR_BIT_WIDTH-1:0] w_addr;

  assign w_valid      = (r_count != 2'd0);
  assign w_pop        = w_valid & out_ready;
  assign w_head_last  = r_buf_last[r_rd_ptr];
  // Occupancy once this cycle's push and pop have settled; a new issue is
  // only safe if its word will still find a free slot next cycle.
  assign w_occ_after  = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue      = (r_state == S_READ) && (w_occ_after < 3'd2);
  assign w_issue_last = w_issue && (r_idx == IDX_LAST);
  assign w_addr       = r_bitrev ? bit_reverse(r_idx) : r_idx;

  // Frame sequencing: IDLE -> READ (issuing) -> DRAIN (emptying) -> DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_bitrev <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bitrev <= bitrev_en;
            r_idx    <= '0;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_idx <= r_idx + IDX_ONE;
            if (r_idx == IDX_LAST) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head_last) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read issue: address held between issues, inflight marks next-cycle capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_read_addr     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      if (w_issue) begin
        r_read_addr <= w_addr;
      end
    end
  end

  // Buffer bookkeeping: pointers and occupancy for simultaneous push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_occ_after[1:0];
    end
  end

  // Buffer storage: capture the RAM word belonging to last cycle's address
  always_ff @(posedge clk) begin
    if (r_inflight) begin
      r_buf_data[r_wr_ptr] <= ram_data;
      r_buf_last[r_wr_ptr] <= r_inflight_last;
    end
  end

  // Outputs are gated by occupancy so stale entries never show through
  assign read_addr = r_read_addr;
  assign out_valid = w_valid;
  assign out_data  = w_valid ? r_buf_data[r_rd_ptr] : '0;
  assign out_last  = w_valid & w_head_last;
  assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Bench for fft_bitrev_reader with an 8-word RAM (ADDR_BIT_WIDTH = 3).
// Stimulus pushes expected samples into a scoreboard queue.
// A negedge monitor pops the queue on every handshake and checks:
//   - data and last flag of each sample
//   - stability of stalled outputs
//   - the done pulse following the last handshake
//   - the bit-reversed address sequence
module tb_fft_bitrev_reader;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          bitrev_en;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  fft_bitrev_reader #(.DATA_BIT_WIDTH(DW), .ADDR_BIT_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bitrev_en(bitrev_en),
    .read_addr(read_addr), .ram_data(ram_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address sampled on the falling edge, word = 0x100 + addr
  logic [DW-1:0] mem [N];
  initial begin
    for (int a = 0; a < N; a++) mem[a] = 32'h100 + a;
    ram_data = '0;
  end
  always @(negedge clk) ram_data <= mem[read_addr];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_hs   = 0;

  logic [32:0]   sb_q   [$];
  logic [AW-1:0] addr_q [$];

  // Hand-computed 3-bit bit-reversal of 0..7
  int br_tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;
  logic          exp_done   = 1'b0;
  logic [AW-1:0] prev_addr  = '0;

  always @(negedge clk) begin
    logic [32:0] e;
    logic        hs_last;
    hs_last = 1'b0;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        n_hs++;
        if (sb_q.size() == 0) begin
          check("unexpected_beat", out_data, 32'hDEAD_BEEF);
        end else begin
          e = sb_q.pop_front();
          check("beat_data", out_data, e[31:0]);
          check("beat_last", 32'(out_last), 32'(e[32]));
        end
        hs_last = out_last;
      end
      check("done_pulse", 32'(done), 32'(exp_done));
      if (read_addr != prev_addr && addr_q.size() > 0) begin
        check("issue_addr", 32'(read_addr), 32'(addr_q.pop_front()));
      end
      exp_done   = hs_last;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      exp_done   = 1'b0;
      prev_stall = 1'b0;
    end
    prev_addr = read_addr;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input logic br);
    for (int i = 0; i < N; i++) begin
      int a;
      a = br ? br_tab[i] : i;
      sb_q.push_back({(i == N - 1), 32'h100 + 32'(a)});
    end
  endtask

  task automatic start_frame(input logic br);
    push_frame(br);
    bitrev_en = br;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    bitrev_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      tick();
      if (done) got = 1'b1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic check_stream(input string name);
    for (int k = 0; k < N; k++) begin
      check(name, 32'(out_valid), 32'd1);
      tick();
    end
    check({name, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] pat;
    logic       got;
    int         base;

    rst_n     = 1'b0;
    start     = 1'b0;
    bitrev_en = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_addr", 32'(read_addr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // 1: natural order, full throughput, latency
    start_frame(1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid_e0", 32'(out_valid), 32'd0);
    tick();
    check("t1_addr_e1", 32'(read_addr), 32'd0);
    check("t1_valid_e1", 32'(out_valid), 32'd0);
    tick();
    check("t1_first", out_data, 32'h100);
    check_stream("t1_stream");
    check("t1_done_busy", 32'(busy), 32'd0);
    tick();
    check("t1_idle_done", 32'(done), 32'd0);

    // 2: bit-reversed order with address sequence
    for (int i = 0; i < N; i++) addr_q.push_back(AW'(br_tab[i]));
    start_frame(1'b1);
    wait_done("t2_done");
    tick();
    check("t2_addr_all", 32'(addr_q.size()), 32'd0);

    // 3: random backpressure
    pat = 4'b1001;
    push_frame(1'b0);
    start = 1'b1;
    got   = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      out_ready = (c < 4) ? pat[3 - c] : 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      if (done) got = 1'b1;
    end
    check("t3_done", 32'(got), 32'd1);
    out_ready = 1'b1;
    tick();

    // 4: stalled from start, two issues only, then full rate
    out_ready = 1'b0;
    start_frame(1'b0);
    repeat (10) tick();
    check("t4_addr", 32'(read_addr), 32'd1);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_data", out_data, 32'h100);
    out_ready = 1'b1;
    check_stream("t4_resume");
    tick();

    // 5: start mid-frame ignored; start right after done accepted
    start_frame(1'b0);
    repeat (3) tick();
    bitrev_en = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    bitrev_en = 1'b0;
    wait_done("t5a_done");
    tick();
    start_frame(1'b1);
    wait_done("t5b_done");
    tick();
    check("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // 6: reset mid-frame, then a fresh frame
    base = n_hs;
    start_frame(1'b0);
    for (int c = 0; c < 50 && (n_hs - base) < 3; c++) tick();
    check("t6_reached", 32'(n_hs - base), 32'd3);
    rst_n = 1'b0;
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    check("t6_addr", 32'(read_addr), 32'd0);
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_data", out_data, 32'd0);
    check("t6_last", 32'(out_last), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    repeat (4) tick();
    check("t6_idle_busy", 32'(busy), 32'd0);
    start_frame(1'b0);
    wait_done("t6_done_fresh");
    tick();

    check("end_sb_empty", 32'(sb_q.size()), 32'd0);
    check("end_addr_empty", 32'(addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
